hawk_comp_wr_mngr: RTL and testbench

Write-side counterpart of the decompression read manager. Drains compressed-page data from the compressor write FIFO and writes it to its compressed-page slot over AXI4. Issues single-beat INCR write transactions (64B each, one outstanding) starting at comp_cPage_byteStart. Signals completion to the page-write manager so it can update the zspage metadata and TOL.

---
 rtl/hawk_comp_wr_mngr.sv | 106 ++++++++++
 tb/tb_hawk_comp_wr_mngr.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hawk_comp_wr_mngr.sv
// Compressed-page writer: drains the compressor FIFO into the page slot as a
// series of single-beat 64B AXI4 writes, one outstanding, then reports completion.
module hawk_comp_wr_mngr #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int MAX_BYTES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              comp_trigger,
  input  logic [ADDR_W-1:0] comp_cPage_byteStart,
  input  logic [12:0]       comp_size,
  input  logic              wrfifo_empty,
  input  logic [DATA_W-1:0] wrfifo_rdata,
  output logic              wrfifo_pop,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  input  logic              awready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready,
  output logic              comp_wr_done,
  output logic              comp_wr_err,
  output logic [6:0]        beats_left,
  output logic [31:0]       CompPgCnt
);

  typedef enum logic [2:0] {
    IDLE, CALC, AW, W, B, DONE, CFG_ERROR, BUS_ERROR
  } state_t;

  localparam logic [12:0] MAX_SZ = 13'(MAX_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] start_q;
  logic [12:0]       size_q;
  logic [12:0]       beats;
  logic              cfg_bad;

  // 13-bit ceil(size/64); only legal sizes (<= MAX_BYTES) reach the AW path
  assign beats   = (size_q + 13'd63) >> 6;
  assign cfg_bad = (size_q > MAX_SZ) || (start_q[5:0] != 6'd0);

  assign awvalid      = (state == AW);
  assign awlen        = 8'd0;
  assign wvalid       = (state == W) && !wrfifo_empty;
  assign wdata        = (state == W) ? wrfifo_rdata : '0;
  assign wlast        = wvalid;
  assign wrfifo_pop   = wvalid && wready;
  assign bready       = (state == B);
  assign comp_wr_done = (state == DONE);
  assign comp_wr_err  = (state == CFG_ERROR) || (state == BUS_ERROR);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      start_q    <= '0;
      size_q     <= '0;
      awaddr     <= '0;
      beats_left <= '0;
      CompPgCnt  <= '0;
    end else begin
      case (state)
        IDLE: if (comp_trigger && !comp_wr_done) begin
          start_q <= comp_cPage_byteStart;
          size_q  <= comp_size;
          state   <= CALC;
        end
        CALC: begin
          if (cfg_bad)            state <= CFG_ERROR;
          else if (beats == '0)   state <= DONE;
          else begin
            awaddr     <= start_q;
            beats_left <= beats[6:0];
            state      <= AW;
          end
        end
        AW: if (awready) state <= W;
        W:  if (wvalid && wready) state <= B;
        B: if (bvalid) begin
          if (bresp != 2'b00) state <= BUS_ERROR;
          else begin
            beats_left <= beats_left - 7'd1;
            if (beats_left == 7'd1) state <= DONE;
            else begin
              awaddr <= awaddr + ADDR_W'(64);
              state  <= AW;
            end
          end
        end
        DONE: begin
          CompPgCnt <= CompPgCnt + 32'd1;
          state     <= IDLE;
        end
        CFG_ERROR, BUS_ERROR: state <= state;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hawk_comp_wr_mngr.sv
// Directed bench: a table of page writes run against a FIFO/AXI slave model,
// plus hand sequences for start latency, zero size and reset during a write.
module tb_hawk_comp_wr_mngr;
  localparam int AW_ = 64;
  localparam int DW  = 512;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          comp_trigger = 1'b0;
  logic [AW_-1:0] comp_cPage_byteStart = '0;
  logic [12:0]   comp_size = '0;
  logic          wrfifo_empty, wrfifo_pop;
  logic [DW-1:0] wrfifo_rdata;
  logic          awvalid, awready, wvalid, wlast, wready, bvalid, bready;
  logic [AW_-1:0] awaddr;
  logic [7:0]    awlen;
  logic [DW-1:0] wdata;
  logic [1:0]    bresp;
  logic          comp_wr_done, comp_wr_err;
  logic [6:0]    beats_left;
  logic [31:0]   CompPgCnt;

  always #5 clk = ~clk;

  hawk_comp_wr_mngr dut (
    .clk_i(clk), .rst_i(rst_i), .comp_trigger(comp_trigger),
    .comp_cPage_byteStart(comp_cPage_byteStart), .comp_size(comp_size),
    .wrfifo_empty(wrfifo_empty), .wrfifo_rdata(wrfifo_rdata), .wrfifo_pop(wrfifo_pop),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .comp_wr_done(comp_wr_done), .comp_wr_err(comp_wr_err),
    .beats_left(beats_left), .CompPgCnt(CompPgCnt)
  );

  function automatic logic [DW-1:0] pat(input int i);
    return {16{32'hC0DE_0000 | 32'(i)}};
  endfunction

  // Slave/FIFO model configuration, written only by the stimulus process
  int          cfg_stall = -1, cfg_gap = -1, cfg_err = -1;
  logic [63:0] cfg_start = '0;
  logic        wready_en = 1'b1;
  localparam int FILL = 100;

  // Model / monitor state, written only by the clocked process
  int rd_idx, gap_left, stall_left, aw_cnt, w_cnt, b_cnt, done_cnt;
  int data_bad, proto_bad, stall_bad, gap_bad;
  logic [63:0] last_addr;
  logic        bvalid_r;

  assign wrfifo_empty = (rd_idx >= FILL) || (gap_left > 0);
  assign wrfifo_rdata = pat(rd_idx);
  assign wready       = wready_en;
  assign bvalid       = bvalid_r;
  assign bresp        = (b_cnt == cfg_err) ? 2'b10 : 2'b00;
  assign awready      = !(aw_cnt == cfg_stall && stall_left > 0);

  always @(posedge clk) begin
    if (rst_i) begin
      rd_idx <= 0; gap_left <= 0; stall_left <= 5; aw_cnt <= 0; w_cnt <= 0;
      b_cnt <= 0; done_cnt <= 0; data_bad <= 0; proto_bad <= 0;
      stall_bad <= 0; gap_bad <= 0; last_addr <= '0; bvalid_r <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_cnt    <= aw_cnt + 1;
        last_addr <= awaddr;
        if (aw_cnt != b_cnt || awaddr != cfg_start + 64'(64 * aw_cnt)) proto_bad <= proto_bad + 1;
        if (aw_cnt == cfg_gap) gap_left <= 3;
      end else if (gap_left > 0) gap_left <= gap_left - 1;
      if (awvalid && !awready) begin
        stall_left <= stall_left - 1;
        if (awaddr != cfg_start + 64'(64 * aw_cnt)) stall_bad <= stall_bad + 1;
      end
      if (awvalid && wvalid) proto_bad <= proto_bad + 1;
      if (gap_left > 0 && (wvalid || wrfifo_pop)) gap_bad <= gap_bad + 1;
      if (wvalid && wready) begin
        w_cnt    <= w_cnt + 1;
        bvalid_r <= 1'b1;
        if (wdata != pat(w_cnt) || !wlast || !wrfifo_pop) data_bad <= data_bad + 1;
      end else if (bvalid_r && bready) bvalid_r <= 1'b0;
      if (bvalid_r && bready) b_cnt <= b_cnt + 1;
      if (wrfifo_pop) rd_idx <= rd_idx + 1;
      if (comp_wr_done) done_cnt <= done_cnt + 1;
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst_i = 1'b1;
    @(negedge clk) rst_i = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      if (done_cnt > 0 || comp_wr_err) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [12:0] size;
    logic [63:0] start;
    int          stall, gap, errb;
    int          exp_aws, exp_done;
    logic        exp_err;
    logic [63:0] exp_last;
  } vec_t;

  task automatic run_vec(input int id, input vec_t v, input bit with_rst);
    bit ok;
    string p;
    p = $sformatf("v%0d", id);
    cfg_stall = v.stall; cfg_gap = v.gap; cfg_err = v.errb; cfg_start = v.start;
    if (with_rst) do_reset();
    @(negedge clk);
    comp_cPage_byteStart = v.start; comp_size = v.size; comp_trigger = 1'b1;
    @(negedge clk) comp_trigger = 1'b0;
    wait_end(ok);
    repeat (5) @(negedge clk);
    chk({p, " finish"},    64'(ok),          64'd1);
    chk({p, " aw_count"},  64'(aw_cnt),      64'(v.exp_aws));
    chk({p, " w_count"},   64'(w_cnt),       64'(v.exp_aws));
    chk({p, " pops"},      64'(rd_idx),      64'(v.exp_aws));
    chk({p, " done_cnt"},  64'(done_cnt),    64'(v.exp_done));
    chk({p, " err"},       64'(comp_wr_err), 64'(v.exp_err));
    chk({p, " pgcnt"},     64'(CompPgCnt),   64'(v.exp_done));
    chk({p, " last_addr"}, last_addr,        v.exp_last);
    chk({p, " data_bad"},  64'(data_bad),    64'd0);
    chk({p, " proto_bad"}, 64'(proto_bad),   64'd0);
    if (v.stall >= 0) begin
      chk({p, " stall_done"}, 64'(stall_left), 64'd0);
      chk({p, " stall_addr"}, 64'(stall_bad),  64'd0);
    end
    if (v.gap >= 0) chk({p, " gap_quiet"}, 64'(gap_bad), 64'd0);
  endtask

  vec_t vecs[9];
  bit   ok;

  initial begin
    vecs[0] = '{13'd200,  64'h8000_1000, -1, -1, -1, 4,  1, 1'b0, 64'h8000_10C0};
    vecs[1] = '{13'd200,  64'h8000_1000,  1, -1, -1, 4,  1, 1'b0, 64'h8000_10C0};
    vecs[2] = '{13'd200,  64'h8000_1000, -1,  2, -1, 4,  1, 1'b0, 64'h8000_10C0};
    vecs[3] = '{13'd200,  64'h8000_1000, -1, -1,  1, 2,  0, 1'b1, 64'h8000_1040};
    vecs[4] = '{13'd4097, 64'h8000_1000, -1, -1, -1, 0,  0, 1'b1, 64'h0};
    vecs[5] = '{13'd64,   64'h8000_1010, -1, -1, -1, 0,  0, 1'b1, 64'h0};
    vecs[6] = '{13'd4096, 64'h4000_0000, -1, -1, -1, 64, 1, 1'b0, 64'h4000_0FC0};
    vecs[7] = '{13'd1,    64'h0,         -1, -1, -1, 1,  1, 1'b0, 64'h0};
    vecs[8] = '{13'd0,    64'h8000_2000, -1, -1, -1, 0,  1, 1'b0, 64'h0};

    do_reset();
    chk("rst awvalid",  64'(awvalid),      64'd0);
    chk("rst wvalid",   64'(wvalid),       64'd0);
    chk("rst bready",   64'(bready),       64'd0);
    chk("rst pop",      64'(wrfifo_pop),   64'd0);
    chk("rst done",     64'(comp_wr_done), 64'd0);
    chk("rst err",      64'(comp_wr_err),  64'd0);
    chk("rst beats",    64'(beats_left),   64'd0);
    chk("rst pgcnt",    64'(CompPgCnt),    64'd0);
    chk("rst awaddr",   awaddr,            64'd0);
    chk("rst awlen",    64'(awlen),        64'd0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i], 1'b1);

    // Start latency: CALC in the cycle after the sampling edge, AW one cycle later
    cfg_stall = -1; cfg_gap = -1; cfg_err = -1; cfg_start = 64'h100;
    do_reset();
    comp_cPage_byteStart = 64'h100; comp_size = 13'd64; comp_trigger = 1'b1;
    @(negedge clk) comp_trigger = 1'b0;
    chk("lat calc awvalid", 64'(awvalid), 64'd0);
    @(negedge clk);
    chk("lat aw awvalid", 64'(awvalid),    64'd1);
    chk("lat aw awaddr",  awaddr,          64'h100);
    chk("lat aw beats",   64'(beats_left), 64'd1);
    wait_end(ok);
    chk("lat finish", 64'(ok), 64'd1);
    @(negedge clk);
    chk("lat beats end", 64'(beats_left), 64'd0);
    chk("lat pgcnt",     64'(CompPgCnt),  64'd1);

    // Zero size: done straight out of CALC, one-cycle pulse, no AW
    do_reset();
    comp_size = 13'd0; comp_trigger = 1'b1;
    @(negedge clk) comp_trigger = 1'b0;
    chk("z0 calc done", 64'(comp_wr_done), 64'd0);
    @(negedge clk);
    chk("z0 done", 64'(comp_wr_done), 64'd1);
    @(negedge clk);
    chk("z0 done drop", 64'(comp_wr_done), 64'd0);
    chk("z0 no aw",     64'(aw_cnt),       64'd0);
    chk("z0 pgcnt",     64'(CompPgCnt),    64'd1);

    // Reset while stalled in W, then a fresh page restarts the count from 0
    run_vec(10, vecs[0], 1'b1);
    wready_en = 1'b0;
    @(negedge clk);
    comp_cPage_byteStart = 64'h8000_1000; comp_size = 13'd200; comp_trigger = 1'b1;
    @(negedge clk) comp_trigger = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (wvalid) ok = 1'b1;
    end
    chk("mid reach W", 64'(ok), 64'd1);
    rst_i = 1'b1;
    @(negedge clk);
    chk("mid awvalid", 64'(awvalid),      64'd0);
    chk("mid wvalid",  64'(wvalid),       64'd0);
    chk("mid pop",     64'(wrfifo_pop),   64'd0);
    chk("mid bready",  64'(bready),       64'd0);
    chk("mid done",    64'(comp_wr_done), 64'd0);
    chk("mid err",     64'(comp_wr_err),  64'd0);
    chk("mid beats",   64'(beats_left),   64'd0);
    chk("mid pgcnt",   64'(CompPgCnt),    64'd0);
    chk("mid awaddr",  awaddr,            64'd0);
    chk("mid wdata",   64'(wdata[63:0]),  64'd0);
    rst_i = 1'b0;
    wready_en = 1'b1;
    run_vec(11, vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
